// File: rtl/stat_display_pkg.sv
// Shared constants, hex segment table and display payload type for stat_display.
package stat_display_pkg;

  localparam int unsigned NUM_DIGITS      = 8;
  localparam int unsigned DIGITS_PER_HALF = 4;
  localparam int unsigned DIG_W           = $clog2(NUM_DIGITS);
  localparam int unsigned CNT_W           = 16;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Two counter values shown side by side on one page
  typedef struct packed {
    logic [CNT_W-1:0] left;
    logic [CNT_W-1:0] right;
  } page_word_t;

  // Active-low g..a pattern; b and d are lowercase
  function automatic logic [6:0] hex_pattern(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'h0:    pat = 7'h40;
      4'h1:    pat = 7'h79;
      4'h2:    pat = 7'h24;
      4'h3:    pat = 7'h30;
      4'h4:    pat = 7'h19;
      4'h5:    pat = 7'h12;
      4'h6:    pat = 7'h02;
      4'h7:    pat = 7'h78;
      4'h8:    pat = 7'h00;
      4'h9:    pat = 7'h10;
      4'hA:    pat = 7'h08;
      4'hB:    pat = 7'h03;
      4'hC:    pat = 7'h46;
      4'hD:    pat = 7'h21;
      4'hE:    pat = 7'h06;
      default: pat = 7'h0E;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/stat_display_hex7seg.sv
// Combinational nibble to active-low seven-segment pattern, with blanking.
module hex7seg
  import stat_display_pkg::*;
(
  input  logic [3:0] nib_i,
  input  logic       blank_i,
  output logic [6:0] pat_c_o
);

  assign pat_c_o = blank_i ? SEG_BLANK : hex_pattern(nib_i);

endmodule

// File: rtl/stat_display.sv
// Snapshots four 16-bit statistics counters and scans two of them onto an 8-digit display.
// Optional leading-zero blanking per half is enabled by defining STAT_DISPLAY_BLANK_ZERO_EN.
module stat_display
  import stat_display_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic             clk,
  input  logic             RST,
  input  logic [CNT_W-1:0] cnt_a,
  input  logic [CNT_W-1:0] cnt_b,
  input  logic [CNT_W-1:0] cnt_c,
  input  logic [CNT_W-1:0] cnt_d,
  input  logic             freeze,
  input  logic             page_btn,
  output logic [7:0]       an,
  output logic [7:0]       seg
);

  localparam int unsigned SCAN_W = $clog2(SCAN_DIV) + 1;
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

  logic [CNT_W-1:0]      snap_a_q, snap_b_q, snap_c_q, snap_d_q;
  logic [CNT_W-1:0]      snap_a_d, snap_b_d, snap_c_d, snap_d_d;
  logic                  btn_q, btn_d;
  logic                  page_q, page_d;
  logic [SCAN_W-1:0]     scan_cnt_q, scan_cnt_d;
  logic [DIG_W-1:0]      digit_idx_q, digit_idx_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [7:0]            seg_q, seg_d;

  page_word_t       word_c;
  logic [CNT_W-1:0] half_c;
  logic [1:0]       nib_sel_c;
  logic [3:0]       nib_c;
  logic             blank_c;
  logic [6:0]       pat_c;
  logic             scan_wrap_c;

  // Select the nibble under the currently lit digit
  always_comb begin
    word_c.left  = page_q ? snap_c_q : snap_a_q;
    word_c.right = page_q ? snap_d_q : snap_b_q;
    half_c       = digit_idx_q[2] ? word_c.left : word_c.right;
    nib_sel_c    = digit_idx_q[1:0];
    nib_c        = half_c[{nib_sel_c, 2'b00} +: 4];
`ifdef STAT_DISPLAY_BLANK_ZERO_EN
    blank_c      = (nib_sel_c != 2'd0) && ((half_c >> {nib_sel_c, 2'b00}) == '0);
`else
    blank_c      = 1'b0;
`endif
  end

  hex7seg u_hex7seg (
    .nib_i   (nib_c),
    .blank_i (blank_c),
    .pat_c_o (pat_c)
  );

  // Next-state: snapshot, page toggle, scan timing and output image
  always_comb begin
    snap_a_d    = snap_a_q;
    snap_b_d    = snap_b_q;
    snap_c_d    = snap_c_q;
    snap_d_d    = snap_d_q;
    btn_d       = page_btn;
    page_d      = page_q ^ (page_btn & ~btn_q);
    scan_wrap_c = (scan_cnt_q == SCAN_LAST);
    scan_cnt_d  = scan_wrap_c ? '0 : scan_cnt_q + SCAN_W'(1);
    digit_idx_d = scan_wrap_c ? digit_idx_q + DIG_W'(1) : digit_idx_q;
    an_d        = ~(NUM_DIGITS'(1) << digit_idx_q);
    seg_d       = {~((digit_idx_q == '0) && page_q), pat_c};
    if (!freeze) begin
      snap_a_d = cnt_a;
      snap_b_d = cnt_b;
      snap_c_d = cnt_c;
      snap_d_d = cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!RST) begin
      snap_a_q    <= '0;
      snap_b_q    <= '0;
      snap_c_q    <= '0;
      snap_d_q    <= '0;
      btn_q       <= 1'b0;
      page_q      <= 1'b0;
      scan_cnt_q  <= '0;
      digit_idx_q <= '0;
      an_q        <= '1;
      seg_q       <= '1;
    end else begin
      snap_a_q    <= snap_a_d;
      snap_b_q    <= snap_b_d;
      snap_c_q    <= snap_c_d;
      snap_d_q    <= snap_d_d;
      btn_q       <= btn_d;
      page_q      <= page_d;
      scan_cnt_q  <= scan_cnt_d;
      digit_idx_q <= digit_idx_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;

endmodule

// File: tb/tb_stat_display.sv
// Scoreboard bench for stat_display: a SCAN_DIV=4 and a SCAN_DIV=1 instance share one stimulus.
module tb_stat_display;

  logic        clk = 1'b0;
  logic        RST;
  logic [15:0] cnt_a, cnt_b, cnt_c, cnt_d;
  logic        freeze, page_btn;
  logic [7:0]  an4, seg4, an1, seg1;

  always #5 clk = ~clk;

  stat_display #(.SCAN_DIV(4)) dut4 (
    .clk(clk), .RST(RST), .cnt_a(cnt_a), .cnt_b(cnt_b), .cnt_c(cnt_c), .cnt_d(cnt_d),
    .freeze(freeze), .page_btn(page_btn), .an(an4), .seg(seg4)
  );

  stat_display #(.SCAN_DIV(1)) dut1 (
    .clk(clk), .RST(RST), .cnt_a(cnt_a), .cnt_b(cnt_b), .cnt_c(cnt_c), .cnt_d(cnt_d),
    .freeze(freeze), .page_btn(page_btn), .an(an1), .seg(seg1)
  );

  typedef struct {
    logic [7:0] an4, seg4, an1, seg1;
  } exp_t;

  typedef struct {
    int         cyc;
    bit         sel1;
    logic [7:0] an, seg;
  } spot_t;

  exp_t  q[$];
  spot_t spots[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Active-low g..a hex patterns, 0..F
  logic [6:0] tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic [15:0] m_snap [4];
  bit          m_page, m_btn;
  int          m_cnt4, m_dig4, m_dig1;

  function automatic logic [7:0] exp_seg(input int d);
    logic [15:0] w, hi;
    logic [6:0]  p;
    int          idx;
    if (d >= 4) w = m_page ? m_snap[2] : m_snap[0];
    else        w = m_page ? m_snap[3] : m_snap[1];
    idx = d % 4;
    hi  = w >> (4 * idx);
    p   = tbl[hi[3:0]];
`ifdef STAT_DISPLAY_BLANK_ZERO_EN
    if (idx != 0 && hi == 16'h0) p = 7'h7F;
`endif
    return {~(d == 0 && m_page), p};
  endfunction

  // Push the expected outputs for the coming posedge, advance the model, wait a cycle
  task automatic tick();
    exp_t e;
    if (!RST) begin
      e = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
      for (int i = 0; i < 4; i++) m_snap[i] = 16'h0;
      m_page = 1'b0; m_btn = 1'b0; m_cnt4 = 0; m_dig4 = 0; m_dig1 = 0;
    end else begin
      e.an4  = ~(8'h01 << m_dig4);
      e.seg4 = exp_seg(m_dig4);
      e.an1  = ~(8'h01 << m_dig1);
      e.seg1 = exp_seg(m_dig1);
      if (!freeze) begin
        m_snap[0] = cnt_a; m_snap[1] = cnt_b; m_snap[2] = cnt_c; m_snap[3] = cnt_d;
      end
      if (page_btn && !m_btn) m_page = !m_page;
      m_btn = page_btn;
      if (m_cnt4 == 3) begin
        m_cnt4 = 0;
        m_dig4 = (m_dig4 + 1) % 8;
      end else begin
        m_cnt4++;
      end
      m_dig1 = (m_dig1 + 1) % 8;
    end
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic add_spot(input int k, input bit sel1, input logic [7:0] a, input logic [7:0] s);
    spot_t sp;
    sp.cyc = cyc + k; sp.sel1 = sel1; sp.an = a; sp.seg = s;
    spots.push_back(sp);
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Monitor: compare every registered output update against the scoreboard
  initial begin
    exp_t  e;
    spot_t s;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("an_div4",  an4,  e.an4);
        check("seg_div4", seg4, e.seg4);
        check("an_div1",  an1,  e.an1);
        check("seg_div1", seg1, e.seg1);
      end
      while (spots.size() > 0 && spots[0].cyc <= cyc) begin
        s = spots.pop_front();
        if (s.cyc < cyc) begin
          total++; bad++;
          $display("FAIL spot_missed: got cycle %0d want cycle %0d", cyc, s.cyc);
        end else begin
          check("spot_an",  s.sel1 ? an1  : an4,  s.an);
          check("spot_seg", s.sel1 ? seg1 : seg4, s.seg);
        end
      end
    end
  end

  initial begin
    int guard;
    RST = 1'b0; freeze = 1'b0; page_btn = 1'b0;
    cnt_a = 16'h1234; cnt_b = 16'hABCD; cnt_c = 16'h0000; cnt_d = 16'h0000;
    ticks(2);

    // Page 0 scan with hand-derived digits
    RST = 1'b1;
    add_spot(3,  1'b0, 8'hFE, 8'hA1);
    add_spot(5,  1'b0, 8'hFD, 8'hC6);
    add_spot(30, 1'b0, 8'h7F, 8'hF9);
    ticks(37);

    // Reset mid-frame, then scan restarts at digit 0 with cleared snapshots
    RST = 1'b0;
    add_spot(1, 1'b0, 8'hFF, 8'hFF);
    tick();
    RST = 1'b1;
    add_spot(1, 1'b0, 8'hFE, 8'hC0);
    add_spot(2, 1'b1, 8'hFD, 8'hC6);
    add_spot(9, 1'b1, 8'hFE, 8'hA1);
    ticks(40);

    // Single page pulse, then a held button
    cnt_c = 16'h00F0; cnt_d = 16'h0007;
    page_btn = 1'b1; tick();
    page_btn = 1'b0; ticks(40);
    page_btn = 1'b1; ticks(20);
    page_btn = 1'b0; ticks(40);

    // Freeze holds old value, unfreeze picks up new
    freeze = 1'b1; tick();
    cnt_a = 16'hFFFF; ticks(40);
    freeze = 1'b0; ticks(40);

    // Input sweep, exercising per-cycle advance of the SCAN_DIV=1 instance
    for (int i = 0; i < 20; i++) begin
      cnt_a = 16'(i * 16'h1111);
      cnt_b = 16'(16'hFEDC - i * 16'h0123);
      cnt_c = 16'(i * 16'h0F0F);
      cnt_d = 16'(16'h8000 >> (i % 16));
      tick();
    end

    // Leading zeros on page 0
    cnt_a = 16'h0000; cnt_b = 16'h00A0; ticks(40);

    // Page edge coinciding with a digit advance
    guard = 0;
    while (m_cnt4 != 3 && guard < 8) begin tick(); guard++; end
    total++;
    if (m_cnt4 != 3) begin
      bad++;
      $display("FAIL align_timeout: got scan %0d want 3", m_cnt4);
    end
    page_btn = 1'b1; tick();
    page_btn = 1'b0; ticks(40);

    @(posedge clk); #2;
    total++;
    if (q.size() != 0 || spots.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d/%0d pending want 0/0", q.size(), spots.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
